// File: rtl/eth_tx_frame_arb.sv
// Round-robin, frame-granular arbiter sharing one Ethernet header + payload AXI stream
// TX path between S_COUNT sources. Grant is taken on header acceptance and held through tlast.
module eth_tx_frame_arb #(
    parameter int S_COUNT    = 2,
    parameter int DATA_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,

    input  logic [S_COUNT-1:0]              s_eth_hdr_valid,
    output logic [S_COUNT-1:0]              s_eth_hdr_ready,
    input  logic [S_COUNT*48-1:0]           s_eth_dest_mac,
    input  logic [S_COUNT*48-1:0]           s_eth_src_mac,
    input  logic [S_COUNT*16-1:0]           s_eth_type,
    input  logic [S_COUNT*DATA_WIDTH-1:0]   s_eth_payload_axis_tdata,
    input  logic [S_COUNT-1:0]              s_eth_payload_axis_tvalid,
    output logic [S_COUNT-1:0]              s_eth_payload_axis_tready,
    input  logic [S_COUNT-1:0]              s_eth_payload_axis_tlast,
    input  logic [S_COUNT-1:0]              s_eth_payload_axis_tuser,

    output logic                            m_eth_hdr_valid,
    input  logic                            m_eth_hdr_ready,
    output logic [47:0]                     m_eth_dest_mac,
    output logic [47:0]                     m_eth_src_mac,
    output logic [15:0]                     m_eth_type,
    output logic [DATA_WIDTH-1:0]           m_eth_payload_axis_tdata,
    output logic                            m_eth_payload_axis_tvalid,
    input  logic                            m_eth_payload_axis_tready,
    output logic                            m_eth_payload_axis_tlast,
    output logic                            m_eth_payload_axis_tuser,

    output logic [S_COUNT-1:0]              grant,
    output logic                            busy
);

    localparam int IDX_W = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAYLOAD
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  sel;
    logic [IDX_W-1:0]  last_grant;
    logic [IDX_W-1:0]  winner;
    logic [IDX_W-1:0]  cand;
    logic              req_found;
    logic [S_COUNT-1:0] winner_onehot;
    logic              frame_done;

    logic [47:0]           dest_arr  [S_COUNT];
    logic [47:0]           src_arr   [S_COUNT];
    logic [15:0]           type_arr  [S_COUNT];
    logic [DATA_WIDTH-1:0] tdata_arr [S_COUNT];

    always_comb begin
        for (int i = 0; i < S_COUNT; i++) begin
            dest_arr[i]  = s_eth_dest_mac[i*48 +: 48];
            src_arr[i]   = s_eth_src_mac[i*48 +: 48];
            type_arr[i]  = s_eth_type[i*16 +: 16];
            tdata_arr[i] = s_eth_payload_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Search starts one past the previous owner so every requester is served within S_COUNT frames.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        req_found = 1'b0;
        winner    = '0;
        cand      = last_grant;
        for (int k = 0; k < S_COUNT; k++) begin
            cand = (int'(cand) == S_COUNT - 1) ? '0 : cand + 1'b1;
            if (!req_found && s_eth_hdr_valid[cand]) begin
                req_found = 1'b1;
                winner    = cand;
            end
        end
    end

    assign winner_onehot = S_COUNT'(1) << winner;

    always_comb begin
        s_eth_hdr_ready           = '0;
        s_eth_payload_axis_tready = '0;
        if (!rst && state == IDLE && req_found) begin
            s_eth_hdr_ready = winner_onehot;
        end
        if (state == PAYLOAD) begin
            s_eth_payload_axis_tready = S_COUNT'(m_eth_payload_axis_tready) << sel;
        end
    end

    assign m_eth_payload_axis_tdata  = tdata_arr[sel];
    assign m_eth_payload_axis_tvalid = (state == PAYLOAD) && s_eth_payload_axis_tvalid[sel];
    assign m_eth_payload_axis_tlast  = s_eth_payload_axis_tlast[sel];
    assign m_eth_payload_axis_tuser  = s_eth_payload_axis_tuser[sel];

    // tuser does not affect the end of the grant; tlast alone closes the frame.
    assign frame_done = m_eth_payload_axis_tvalid && m_eth_payload_axis_tready
                        && m_eth_payload_axis_tlast;

    // NOTE: state is written with non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            sel             <= '0;
            last_grant      <= IDX_W'(S_COUNT - 1);
            grant           <= '0;
            busy            <= 1'b0;
            m_eth_hdr_valid <= 1'b0;
            m_eth_dest_mac  <= '0;
            m_eth_src_mac   <= '0;
            m_eth_type      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_found) begin
                        state           <= HDR;
                        sel             <= winner;
                        grant           <= winner_onehot;
                        busy            <= 1'b1;
                        m_eth_hdr_valid <= 1'b1;
                        m_eth_dest_mac  <= dest_arr[winner];
                        m_eth_src_mac   <= src_arr[winner];
                        m_eth_type      <= type_arr[winner];
                    end
                end
                HDR: begin
                    if (m_eth_hdr_ready) begin
                        state           <= PAYLOAD;
                        m_eth_hdr_valid <= 1'b0;
                    end
                end
                PAYLOAD: begin
                    if (frame_done) begin
                        state      <= IDLE;
                        grant      <= '0;
                        busy       <= 1'b0;
                        last_grant <= sel;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_frame_arb.sv
// Self-checking bench for eth_tx_frame_arb: a cycle table for a single frame, hand sequences
// for stalls, blocking and reset, and randomized traffic checked against a round-robin frame model.
module tb_eth_tx_frame_arb;

    localparam int S    = 2;
    localparam int DW   = 8;
    localparam int MAXF = 16;

    logic clk = 1'b0;
    logic rst;

    logic [S-1:0]    s_eth_hdr_valid;
    logic [S-1:0]    s_eth_hdr_ready;
    logic [S*48-1:0] s_eth_dest_mac;
    logic [S*48-1:0] s_eth_src_mac;
    logic [S*16-1:0] s_eth_type;
    logic [S*DW-1:0] s_eth_payload_axis_tdata;
    logic [S-1:0]    s_eth_payload_axis_tvalid;
    logic [S-1:0]    s_eth_payload_axis_tready;
    logic [S-1:0]    s_eth_payload_axis_tlast;
    logic [S-1:0]    s_eth_payload_axis_tuser;
    logic            m_eth_hdr_valid;
    logic            m_eth_hdr_ready;
    logic [47:0]     m_eth_dest_mac;
    logic [47:0]     m_eth_src_mac;
    logic [15:0]     m_eth_type;
    logic [DW-1:0]   m_eth_payload_axis_tdata;
    logic            m_eth_payload_axis_tvalid;
    logic            m_eth_payload_axis_tready;
    logic            m_eth_payload_axis_tlast;
    logic            m_eth_payload_axis_tuser;
    logic [S-1:0]    grant;
    logic            busy;

    always #4 clk = ~clk;

    eth_tx_frame_arb #(.S_COUNT(S), .DATA_WIDTH(DW)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .s_eth_hdr_valid           (s_eth_hdr_valid),
        .s_eth_hdr_ready           (s_eth_hdr_ready),
        .s_eth_dest_mac            (s_eth_dest_mac),
        .s_eth_src_mac             (s_eth_src_mac),
        .s_eth_type                (s_eth_type),
        .s_eth_payload_axis_tdata  (s_eth_payload_axis_tdata),
        .s_eth_payload_axis_tvalid (s_eth_payload_axis_tvalid),
        .s_eth_payload_axis_tready (s_eth_payload_axis_tready),
        .s_eth_payload_axis_tlast  (s_eth_payload_axis_tlast),
        .s_eth_payload_axis_tuser  (s_eth_payload_axis_tuser),
        .m_eth_hdr_valid           (m_eth_hdr_valid),
        .m_eth_hdr_ready           (m_eth_hdr_ready),
        .m_eth_dest_mac            (m_eth_dest_mac),
        .m_eth_src_mac             (m_eth_src_mac),
        .m_eth_type                (m_eth_type),
        .m_eth_payload_axis_tdata  (m_eth_payload_axis_tdata),
        .m_eth_payload_axis_tvalid (m_eth_payload_axis_tvalid),
        .m_eth_payload_axis_tready (m_eth_payload_axis_tready),
        .m_eth_payload_axis_tlast  (m_eth_payload_axis_tlast),
        .m_eth_payload_axis_tuser  (m_eth_payload_axis_tuser),
        .grant                     (grant),
        .busy                      (busy)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame contents are a pure function of (source, frame index, beat) so the model needs no storage.
    function automatic logic [47:0] f_dest(input int i, input int f);
        return 48'h0A0000000000 + 48'(i * 4096 + f);
    endfunction
    function automatic logic [47:0] f_src(input int i, input int f);
        return 48'h020000000000 + 48'(i * 256 + f + 1);
    endfunction
    function automatic logic [15:0] f_type(input int i, input int f);
        return 16'h0800 + 16'(i * 16 + f);
    endfunction
    function automatic logic [7:0] f_byte(input int i, input int f, input int b);
        return 8'(i * 97 + f * 31 + b * 7 + 3);
    endfunction
    function automatic logic f_user(input int f);
        return (f % 3) == 2;
    endfunction

    function automatic int rr_pick(input logic [S-1:0] v, input int last);
        for (int k = 1; k <= S; k++) begin
            int idx = (last + k) % S;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // Source drivers
    int nfr[S];
    int flen[S][MAXF];
    int start_cyc[S];
    int fcur[S];
    int beat[S];
    bit in_pay[S];
    bit all_valid;
    int tr_mode;      // 0 random readies, 1 payload ready toggles, 2 readies held high
    int stop_beat;

    // Reference model of the frame-level protocol
    int m_last;
    bit m_busy, m_hdr_pend, m_pay;
    int m_owner, m_fidx, m_beat;
    int delivered, beats_out;
    int order_q[$];
    int tlast_q[$];
    int acc_cyc[S];

    task automatic model_reset();
        m_last     = S - 1;
        m_busy     = 1'b0;
        m_hdr_pend = 1'b0;
        m_pay      = 1'b0;
        m_owner    = 0;
        m_fidx     = 0;
        m_beat     = 0;
    endtask

    task automatic zero_inputs();
        s_eth_hdr_valid           = '0;
        s_eth_dest_mac            = '0;
        s_eth_src_mac             = '0;
        s_eth_type                = '0;
        s_eth_payload_axis_tdata  = '0;
        s_eth_payload_axis_tvalid = '0;
        s_eth_payload_axis_tlast  = '0;
        s_eth_payload_axis_tuser  = '0;
        m_eth_hdr_ready           = 1'b0;
        m_eth_payload_axis_tready = 1'b0;
    endtask

    task automatic reset_all();
        rst = 1'b1;
        zero_inputs();
        s_eth_hdr_valid           = '1;
        s_eth_payload_axis_tvalid = '1;
        m_eth_payload_axis_tready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hdr_ready", s_eth_hdr_ready, '0);
        check("rst_pay_ready", s_eth_payload_axis_tready, '0);
        check("rst_ctrl", {grant, busy, m_eth_hdr_valid, m_eth_payload_axis_tvalid}, '0);
        check("rst_hdr_regs", {m_eth_dest_mac, m_eth_type}, '0);
        zero_inputs();
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_sources(input int cyc);
        bit pend;
        for (int i = 0; i < S; i++) begin
            pend = (fcur[i] < nfr[i]) && (cyc >= start_cyc[i]);
            s_eth_dest_mac[i*48 +: 48]         = f_dest(i, fcur[i]);
            s_eth_src_mac[i*48 +: 48]          = f_src(i, fcur[i]);
            s_eth_type[i*16 +: 16]             = f_type(i, fcur[i]);
            s_eth_payload_axis_tdata[i*DW +: DW] = f_byte(i, fcur[i], beat[i]);
            s_eth_payload_axis_tlast[i]        = (beat[i] == flen[i][fcur[i]] - 1);
            s_eth_payload_axis_tuser[i]        = s_eth_payload_axis_tlast[i] && f_user(fcur[i]);
            s_eth_hdr_valid[i]                 = !in_pay[i] && pend
                                                 && (all_valid || $urandom_range(0, 2) != 0);
            s_eth_payload_axis_tvalid[i]       = in_pay[i]
                                                 && (all_valid || $urandom_range(0, 2) != 0);
        end
    endtask

    task automatic check_cycle(input int cyc);
        logic [S-1:0] exp_hr, exp_pr, exp_g;
        logic         exp_mv, exp_last;
        int           w;
        w      = m_busy ? -1 : rr_pick(s_eth_hdr_valid, m_last);
        exp_hr = (w >= 0) ? (S'(1) << w) : '0;
        exp_g  = m_busy ? (S'(1) << m_owner) : '0;
        check("hdr_ready", s_eth_hdr_ready, exp_hr);
        check("grant", grant, exp_g);
        check("busy", busy, m_busy);
        check("m_hdr_valid", m_eth_hdr_valid, m_hdr_pend);
        if (m_hdr_pend) begin
            check("m_hdr_fields", {m_eth_dest_mac, m_eth_type},
                  {f_dest(m_owner, m_fidx), f_type(m_owner, m_fidx)});
            check("m_src_mac", m_eth_src_mac, f_src(m_owner, m_fidx));
        end
        exp_pr = m_pay ? (S'(m_eth_payload_axis_tready) << m_owner) : '0;
        check("pay_ready", s_eth_payload_axis_tready, exp_pr);
        exp_mv = m_pay && s_eth_payload_axis_tvalid[m_owner];
        check("m_tvalid", m_eth_payload_axis_tvalid, exp_mv);
        exp_last = (m_beat == flen[m_owner][m_fidx] - 1);
        if (exp_mv && m_eth_payload_axis_tready) begin
            check("m_tdata", m_eth_payload_axis_tdata, f_byte(m_owner, m_fidx, m_beat));
            check("m_tlast_tuser", {m_eth_payload_axis_tlast, m_eth_payload_axis_tuser},
                  {exp_last, exp_last && f_user(m_fidx)});
        end

        if (w >= 0) begin
            m_busy     = 1'b1;
            m_owner    = w;
            m_fidx     = fcur[w];
            m_hdr_pend = 1'b1;
            order_q.push_back(w);
            acc_cyc[w] = cyc;
        end else if (m_hdr_pend && m_eth_hdr_ready) begin
            m_hdr_pend = 1'b0;
            m_pay      = 1'b1;
            m_beat     = 0;
        end else if (exp_mv && m_eth_payload_axis_tready) begin
            beats_out++;
            if (exp_last) begin
                m_busy = 1'b0;
                m_pay  = 1'b0;
                m_last = m_owner;
                delivered++;
                tlast_q.push_back(cyc);
            end else begin
                m_beat++;
            end
        end

        for (int i = 0; i < S; i++) begin
            if (s_eth_hdr_valid[i] && s_eth_hdr_ready[i]) begin
                in_pay[i] = 1'b1;
                beat[i]   = 0;
            end else if (s_eth_payload_axis_tvalid[i] && s_eth_payload_axis_tready[i]) begin
                if (s_eth_payload_axis_tlast[i]) begin
                    in_pay[i] = 1'b0;
                    fcur[i]++;
                end else begin
                    beat[i]++;
                end
            end
        end
    endtask

    task automatic run_frames();
        int total = 0;
        int cyc   = 0;
        for (int i = 0; i < S; i++) begin
            total  += nfr[i];
            fcur[i] = 0;
            beat[i] = 0;
            in_pay[i] = 1'b0;
        end
        delivered = 0;
        beats_out = 0;
        order_q.delete();
        tlast_q.delete();
        while (delivered < total && cyc < 4000) begin
            drive_sources(cyc);
            if (stop_beat >= 0 && m_pay && m_beat == stop_beat) return;
            m_eth_hdr_ready           = (tr_mode == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            m_eth_payload_axis_tready = (tr_mode == 0) ? 1'($urandom_range(0, 1)) :
                                        (tr_mode == 1) ? 1'(cyc % 2) : 1'b1;
            @(negedge clk);
            check_cycle(cyc);
            @(posedge clk);
            #1;
            cyc++;
        end
        check("frames_done", 64'(delivered), 64'(total));
    endtask

    task automatic set_plan(input int n0, input int n1, input int s0, input int s1,
                            input bit av, input int trm);
        nfr[0] = n0; nfr[1] = n1;
        start_cyc[0] = s0; start_cyc[1] = s1;
        all_valid = av;
        tr_mode   = trm;
        stop_beat = -1;
    endtask

    typedef struct {
        logic [S-1:0] hv;  logic pv; logic pl; logic [7:0] pd; logic mhr; logic mpr;
        logic [S-1:0] e_hr; logic [S-1:0] e_pr; logic [S-1:0] e_g;
        logic e_mhv; logic e_mv; logic e_ml; logic e_busy; logic [7:0] e_md;
        logic chk_hdr; logic [47:0] e_dest; logic [15:0] e_type;
    } vec_t;

    localparam logic [47:0] D0 = 48'h5414A7124DB3;
    localparam logic [15:0] T0 = 16'h88B5;
    localparam logic [47:0] D1 = 48'h112233445566;
    localparam logic [15:0] T1 = 16'h0800;

    vec_t vecs[10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            hv     pv pl pd     mhr mpr  e_hr   e_pr   e_g    mhv mv ml bsy md    chk dest type
        vecs[0] = '{2'b01, 0, 0, 8'h00, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 8'h00, 0, D0, T0};
        vecs[1] = '{2'b00, 1, 0, 8'hDE, 0, 0, 2'b00, 2'b00, 2'b01, 1, 0, 0, 1, 8'h00, 1, D0, T0};
        vecs[2] = '{2'b00, 1, 0, 8'hDE, 1, 0, 2'b00, 2'b00, 2'b01, 1, 0, 0, 1, 8'h00, 1, D0, T0};
        vecs[3] = '{2'b00, 1, 0, 8'hDE, 0, 1, 2'b00, 2'b01, 2'b01, 0, 1, 0, 1, 8'hDE, 0, D0, T0};
        vecs[4] = '{2'b00, 1, 0, 8'hAD, 0, 0, 2'b00, 2'b00, 2'b01, 0, 1, 0, 1, 8'hAD, 0, D0, T0};
        vecs[5] = '{2'b00, 1, 0, 8'hAD, 0, 1, 2'b00, 2'b01, 2'b01, 0, 1, 0, 1, 8'hAD, 0, D0, T0};
        vecs[6] = '{2'b00, 1, 0, 8'hBE, 0, 1, 2'b00, 2'b01, 2'b01, 0, 1, 0, 1, 8'hBE, 0, D0, T0};
        vecs[7] = '{2'b00, 1, 1, 8'hEF, 0, 1, 2'b00, 2'b01, 2'b01, 0, 1, 1, 1, 8'hEF, 0, D0, T0};
        vecs[8] = '{2'b10, 0, 0, 8'h00, 0, 0, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 8'h00, 0, D0, T0};
        vecs[9] = '{2'b00, 0, 0, 8'h00, 0, 0, 2'b00, 2'b00, 2'b10, 1, 0, 0, 1, 8'h00, 1, D1, T1};

        rst = 1'b1;
        zero_inputs();
        model_reset();
        reset_all();

        // Single frame from source 0, cycle by cycle, then source 1 wins the next arbitration
        s_eth_dest_mac = {D1, D0};
        s_eth_src_mac  = {48'h020000000002, 48'h020000000001};
        s_eth_type     = {T1, T0};
        for (int r = 0; r < 10; r++) begin
            s_eth_hdr_valid                = vecs[r].hv;
            s_eth_payload_axis_tvalid      = {1'b0, vecs[r].pv};
            s_eth_payload_axis_tlast       = {1'b0, vecs[r].pl};
            s_eth_payload_axis_tdata[7:0]  = vecs[r].pd;
            m_eth_hdr_ready                = vecs[r].mhr;
            m_eth_payload_axis_tready      = vecs[r].mpr;
            @(negedge clk);
            check($sformatf("vec%0d_ctrl", r),
                  {s_eth_hdr_ready, s_eth_payload_axis_tready, grant, m_eth_hdr_valid,
                   m_eth_payload_axis_tvalid, busy},
                  {vecs[r].e_hr, vecs[r].e_pr, vecs[r].e_g, vecs[r].e_mhv, vecs[r].e_mv,
                   vecs[r].e_busy});
            if (vecs[r].e_mv)
                check($sformatf("vec%0d_data", r),
                      {m_eth_payload_axis_tdata, m_eth_payload_axis_tlast},
                      {vecs[r].e_md, vecs[r].e_ml});
            if (vecs[r].chk_hdr)
                check($sformatf("vec%0d_hdr", r), {m_eth_dest_mac, m_eth_type},
                      {vecs[r].e_dest, vecs[r].e_type});
            @(posedge clk);
            #1;
        end
        reset_all();

        // Header held off for 10 cycles while the source changes its header inputs
        s_eth_hdr_valid = 2'b01;
        s_eth_dest_mac[47:0] = f_dest(0, 0);
        s_eth_type[15:0]     = f_type(0, 0);
        @(negedge clk);
        check("stall_accept", s_eth_hdr_ready, 2'b01);
        @(posedge clk);
        #1;
        for (int c = 0; c < 10; c++) begin
            s_eth_hdr_valid              = 2'b00;
            s_eth_dest_mac[47:0]         = 48'(~c);
            s_eth_type[15:0]             = 16'(c);
            s_eth_payload_axis_tvalid    = 2'b01;
            m_eth_hdr_ready              = 1'b0;
            m_eth_payload_axis_tready    = 1'b1;
            @(negedge clk);
            check("stall_hdr_valid", m_eth_hdr_valid, 1'b1);
            check("stall_hdr_fields", {m_eth_dest_mac, m_eth_type}, {f_dest(0, 0), f_type(0, 0)});
            check("stall_pay", {s_eth_payload_axis_tready, m_eth_payload_axis_tvalid}, '0);
            @(posedge clk);
            #1;
        end
        m_eth_hdr_ready = 1'b1;
        @(negedge clk);
        check("stall_release", m_eth_hdr_valid, 1'b1);
        @(posedge clk);
        #1;
        m_eth_hdr_ready = 1'b0;
        @(negedge clk);
        check("stall_to_payload", {m_eth_hdr_valid, s_eth_payload_axis_tready}, {1'b0, 2'b01});
        reset_all();

        // Both sources request continuously, three frames each
        set_plan(3, 3, 0, 0, 1'b1, 2);
        for (int f = 0; f < 3; f++) begin
            flen[0][f] = 3 + f;
            flen[1][f] = 5 - f;
        end
        run_frames();
        for (int k = 0; k < 6; k++)
            check($sformatf("order_%0d", k), 64'(order_q.size() > k ? order_q[k] : -1), 64'(k % 2));

        // 64-byte frame with payload ready toggling every cycle
        set_plan(1, 0, 0, 0, 1'b1, 1);
        flen[0][0] = 64;
        run_frames();
        check("beats_64", 64'(beats_out), 64'd64);

        // Source 1 requests while source 0 is mid-payload
        set_plan(1, 1, 0, 4, 1'b1, 2);
        flen[0][0] = 8;
        flen[1][0] = 3;
        run_frames();
        check("block_order", {64'(order_q.size() > 1 ? order_q[1] : -1)}, 64'd1);
        check("block_grant_cycle", 64'(acc_cyc[1]),
              64'(tlast_q.size() > 0 ? tlast_q[0] + 1 : -1));

        // Randomized traffic with random valids, readies and frame lengths
        set_plan(4 + $urandom_range(0, 6), 4 + $urandom_range(0, 6),
                 $urandom_range(0, 5), $urandom_range(0, 5), 1'b0, 0);
        for (int i = 0; i < S; i++)
            for (int f = 0; f < MAXF; f++)
                flen[i][f] = 1 + $urandom_range(0, 11);
        run_frames();

        // Reset asserted during payload beat 3
        set_plan(1, 1, 0, 2, 1'b1, 2);
        flen[0][0] = 8;
        flen[1][0] = 2;
        stop_beat  = 3;
        run_frames();
        check("pre_rst_tvalid", m_eth_payload_axis_tvalid, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_async_ready", {s_eth_hdr_ready, s_eth_payload_axis_tready}, '0);
        check("rst_async_ctrl", {grant, busy, m_eth_hdr_valid, m_eth_payload_axis_tvalid}, '0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        zero_inputs();
        @(posedge clk);
        #1;
        s_eth_hdr_valid = 2'b11;
        @(negedge clk);
        check("rst_first_winner", s_eth_hdr_ready, 2'b01);
        @(posedge clk);
        #1;
        reset_all();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
